exec_mem_csr_unit: RTL and testbench

- Execute/memory/system slice of the single-cycle RV32I core, between decode (IDU/GPR/ImmGen) and writeback/next-PC logic.
- Contains a combinational 32-bit ALU, a byte-addressable data RAM with RV32I load/store sizing, and a machine-mode CSR file with ecall/mret trap support.
- Data RAM address is the ALU result.

---
 rtl/exec_mem_csr_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_exec_mem_csr_unit.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_csr_unit.sv
// exec_mem_csr_unit
//   Execute / memory / system slice of a single-cycle RV32I core.
//   - Combinational 32-bit ALU; its result is also the data RAM byte address.
//   - Byte-addressable data RAM: combinational sized loads, clocked byte-enable stores.
//   - Machine-mode CSR file (mstatus, mtvec, mscratch, mepc, mcause) with ecall/mret.
//   Optional feature macro: CSR_MCYCLE_EN adds a 64-bit mcycle counter at 0xB00/0xB80.
// Ports:
//   clk, rst (async, active-low)
//   alu_src1/alu_src2/alu_op -> alu_result, alu_zero, alu_less_than
//   mem_read/mem_write/mem_wdata/funct3 -> mem_rdata
//   csr_addr/csr_wdata/csr_write/csr_op -> csr_rdata
//   pc/ecall/mret -> trap_flag, trap_pc
module exec_mem_csr_unit #(
  parameter int unsigned MEM_DEPTH = 16384,
  parameter logic [31:0] MEM_BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  input  logic [3:0]  alu_op,
  output logic [31:0] alu_result,
  output logic        alu_zero,
  output logic        alu_less_than,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] mem_rdata,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_write,
  input  logic [2:0]  csr_op,
  output logic [31:0] csr_rdata,
  input  logic [31:0] pc,
  input  logic        ecall,
  input  logic        mret,
  output logic        trap_flag,
  output logic [31:0] trap_pc
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;

  // ---------------- ALU ----------------
  assign alu_less_than = $signed(alu_src1) < $signed(alu_src2);

  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'd0:    alu_result = alu_src1 + alu_src2;
      4'd1:    alu_result = alu_src1 - alu_src2;
      4'd2:    alu_result = alu_src1 << alu_src2[4:0];
      4'd3:    alu_result = {31'b0, alu_less_than};
      4'd4:    alu_result = {31'b0, alu_src1 < alu_src2};
      4'd5:    alu_result = alu_src1 ^ alu_src2;
      4'd6:    alu_result = alu_src1 >> alu_src2[4:0];
      4'd7:    alu_result = 32'($signed(alu_src1) >>> alu_src2[4:0]);
      4'd8:    alu_result = alu_src1 | alu_src2;
      4'd9:    alu_result = alu_src1 & alu_src2;
      4'd10:   alu_result = alu_src2;
      default: alu_result = '0;
    endcase
  end

  assign alu_zero = (alu_result == 32'd0);

  // ---------------- Data RAM ----------------
  logic [31:0]   mem [MEM_DEPTH];
  logic [AW-1:0] widx;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [3:0]    be;
  logic [31:0]   wd_lane;

  // Offset from the base, in words; truncation gives the wrap-around.
  assign widx  = AW'((alu_result - MEM_BASE) >> 2);
  assign rword = mem[widx];
  assign rbyte = rword[{alu_result[1:0], 3'b000} +: 8];
  assign rhalf = alu_result[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    mem_rdata = '0;
    if (mem_read) begin
      case (funct3)
        3'b000:  mem_rdata = {{24{rbyte[7]}}, rbyte};
        3'b001:  mem_rdata = {{16{rhalf[15]}}, rhalf};
        3'b100:  mem_rdata = {24'b0, rbyte};
        3'b101:  mem_rdata = {16'b0, rhalf};
        default: mem_rdata = rword;
      endcase
    end
  end

  always_comb begin
    be      = 4'b0000;
    wd_lane = mem_wdata;
    case (funct3)
      3'b000: begin
        be      = 4'b0001 << alu_result[1:0];
        wd_lane = {4{mem_wdata[7:0]}};
      end
      3'b001: begin
        be      = alu_result[1] ? 4'b1100 : 4'b0011;
        wd_lane = {2{mem_wdata[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // RAM has no reset; stores complete even while rst is asserted.
  always_ff @(posedge clk) begin
    if (mem_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wd_lane[8*i +: 8];
      end
    end
  end

  // ---------------- CSR file ----------------
  logic [31:0] mstatus, mtvec, mscratch, mepc, mcause;
  logic [31:0] csr_new;
  logic        csr_we;

`ifdef CSR_MCYCLE_EN
  logic [63:0] mcycle;
`endif

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      A_MSTATUS:  csr_rdata = mstatus;
      A_MTVEC:    csr_rdata = mtvec;
      A_MSCRATCH: csr_rdata = mscratch;
      A_MEPC:     csr_rdata = mepc;
      A_MCAUSE:   csr_rdata = mcause;
`ifdef CSR_MCYCLE_EN
      A_MCYCLE:   csr_rdata = mcycle[31:0];
      A_MCYCLEH:  csr_rdata = mcycle[63:32];
`endif
      default:    csr_rdata = '0;
    endcase
  end

  // Set/clear with a zero mask is a pure read and must not disturb the CSR.
  always_comb begin
    csr_new = csr_rdata;
    csr_we  = 1'b0;
    case (csr_op)
      3'b001, 3'b101: begin
        csr_new = csr_wdata;
        csr_we  = 1'b1;
      end
      3'b010, 3'b110: begin
        csr_new = csr_rdata | csr_wdata;
        csr_we  = (csr_wdata != 32'd0);
      end
      3'b011, 3'b111: begin
        csr_new = csr_rdata & ~csr_wdata;
        csr_we  = (csr_wdata != 32'd0);
      end
      default: csr_we = 1'b0;
    endcase
    csr_we = csr_we && csr_write && !ecall && !mret;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus  <= 32'h0000_1800;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else if (ecall) begin
      mepc   <= pc & 32'hFFFF_FFFC;
      mcause <= 32'd11;
    end else if (csr_we) begin
      case (csr_addr)
        A_MSTATUS:  mstatus  <= csr_new;
        A_MTVEC:    mtvec    <= csr_new & 32'hFFFF_FFFC;
        A_MSCRATCH: mscratch <= csr_new;
        A_MEPC:     mepc     <= csr_new & 32'hFFFF_FFFC;
        A_MCAUSE:   mcause   <= csr_new;
        default:    ;
      endcase
    end
  end

`ifdef CSR_MCYCLE_EN
  // A write to either half suppresses the increment for that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle <= '0;
    end else if (csr_we && csr_addr == A_MCYCLE) begin
      mcycle <= {mcycle[63:32], csr_new};
    end else if (csr_we && csr_addr == A_MCYCLEH) begin
      mcycle <= {csr_new, mcycle[31:0]};
    end else begin
      mcycle <= mcycle + 64'd1;
    end
  end
`endif

  // ---------------- Trap redirect ----------------
  always_comb begin
    trap_flag = 1'b0;
    trap_pc   = '0;
    if (ecall) begin
      trap_flag = 1'b1;
      trap_pc   = mtvec;
    end else if (mret) begin
      trap_flag = 1'b1;
      trap_pc   = mepc;
    end
  end

endmodule

// File: tb/tb_exec_mem_csr_unit.sv
// Scoreboard bench for exec_mem_csr_unit: stimulus pushes expected outputs,
// a separate monitor pops and compares them against the live DUT outputs.
module tb_exec_mem_csr_unit;

  localparam int unsigned DEPTH = 16384;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero, alu_less_than;
  logic        mem_read, mem_write;
  logic [31:0] mem_wdata, mem_rdata;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_write;
  logic [2:0]  csr_op;
  logic [31:0] pc, trap_pc;
  logic        ecall, mret, trap_flag;

  always #20 clk = ~clk;

  exec_mem_csr_unit #(.MEM_DEPTH(DEPTH), .MEM_BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_less_than(alu_less_than),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .funct3(funct3), .mem_rdata(mem_rdata),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_write(csr_write),
    .csr_op(csr_op), .csr_rdata(csr_rdata),
    .pc(pc), .ecall(ecall), .mret(mret),
    .trap_flag(trap_flag), .trap_pc(trap_pc)
  );

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  event  ev_sample;
  int    n_checks = 0;
  int    n_err    = 0;

  // ---------------- reference model state ----------------
  logic [31:0] ref_mem [int];
  logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;

  function automatic void model_reset();
    m_mstatus  = 32'h0000_1800;
    m_mtvec    = 0;
    m_mscratch = 0;
    m_mepc     = 0;
    m_mcause   = 0;
  endfunction

  function automatic logic [31:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << sh;
      4'd3:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd4:    return (a < b) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return a >> sh;
      4'd7:    return (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd8:    return a | b;
      4'd9:    return a & b;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int widx_of(logic [31:0] addr);
    logic [31:0] w;
    w = (addr - BASE) / 4;
    return int'(w % DEPTH);
  endfunction

  function automatic logic [31:0] load_ref(logic [31:0] addr, logic [2:0] f3);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = ref_mem[widx_of(addr)];
    b = 8'((w >> (8 * (addr % 4))) & 32'hFF);
    h = 16'((w >> (16 * ((addr / 2) % 2))) & 32'hFFFF);
    case (f3)
      3'd0:    return b[7]  ? (32'hFFFF_FF00 | 32'(b)) : 32'(b);
      3'd1:    return h[15] ? (32'hFFFF_0000 | 32'(h)) : 32'(h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic void store_ref(logic [31:0] addr, logic [2:0] f3, logic [31:0] d);
    int          i;
    logic [31:0] w, m;
    int          sh;
    i = widx_of(addr);
    w = ref_mem.exists(i) ? ref_mem[i] : 32'd0;
    case (f3)
      3'd0: begin sh = 8 * int'(addr % 4);        m = 32'hFF   << sh; end
      3'd1: begin sh = 16 * int'((addr / 2) % 2); m = 32'hFFFF << sh; end
      3'd2: begin sh = 0;                         m = 32'hFFFF_FFFF; end
      default: return;
    endcase
    ref_mem[i] = (w & ~m) | ((d << sh) & m);
  endfunction

  function automatic logic [31:0] csr_rd(logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void csr_apply(logic [11:0] a, logic [2:0] op, logic [31:0] wd);
    logic [31:0] nv, old;
    old = csr_rd(a);
    if (op == 3'd1 || op == 3'd5)      nv = wd;
    else if (op == 3'd2 || op == 3'd6) begin if (wd == 0) return; nv = old | wd;  end
    else if (op == 3'd3 || op == 3'd7) begin if (wd == 0) return; nv = old & ~wd; end
    else return;
    case (a)
      12'h300: m_mstatus  = nv;
      12'h305: m_mtvec    = nv & ~32'd3;
      12'h340: m_mscratch = nv;
      12'h341: m_mepc     = nv & ~32'd3;
      12'h342: m_mcause   = nv;
      default: ;
    endcase
  endfunction

  // ---------------- scoreboard plumbing ----------------
  function automatic logic [31:0] act_of(int sel);
    case (sel)
      0:       return alu_result;
      1:       return {31'b0, alu_zero};
      2:       return {31'b0, alu_less_than};
      3:       return mem_rdata;
      4:       return csr_rdata;
      5:       return {31'b0, trap_flag};
      default: return trap_pc;
    endcase
  endfunction

  initial begin
    forever begin
      @(ev_sample);
      while (q.size() > 0) begin
        item_t       it;
        logic [31:0] a;
        it = q.pop_front();
        a  = act_of(it.sel);
        n_checks++;
        if (a !== it.exp) begin
          n_err++;
          $display("FAIL %s: got %08h expected %08h", it.name, a, it.exp);
        end
      end
    end
  end

  task automatic push(int sel, logic [31:0] e, string n);
    item_t it;
    it.sel = sel; it.exp = e; it.name = n;
    q.push_back(it);
  endtask

  task automatic fire();
    -> ev_sample;
    #1;
  endtask

  task automatic idle();
    alu_src1 = 0; alu_src2 = 0; alu_op = 0;
    mem_read = 0; mem_write = 0; mem_wdata = 0; funct3 = 0;
    csr_addr = 0; csr_wdata = 0; csr_write = 0; csr_op = 0;
    pc = 0; ecall = 0; mret = 0;
  endtask

  // Settle, then queue the model's view of every output for the current inputs.
  task automatic begin_cycle();
    logic [31:0] ae;
    #1;
    ae = alu_ref(alu_src1, alu_src2, alu_op);
    push(0, ae, "alu_result");
    push(1, (ae == 0) ? 32'd1 : 32'd0, "alu_zero");
    push(2, (int'(alu_src1) < int'(alu_src2)) ? 32'd1 : 32'd0, "alu_less_than");
    push(3, mem_read ? load_ref(ae, funct3) : 32'd0, "mem_rdata");
    push(4, csr_rd(csr_addr), "csr_rdata");
    push(5, (ecall || mret) ? 32'd1 : 32'd0, "trap_flag");
    push(6, ecall ? m_mtvec : (mret ? m_mepc : 32'd0), "trap_pc");
  endtask

  // Check, commit the cycle's effects into the model, and move to the next negedge.
  task automatic end_cycle();
    logic [31:0] ae;
    fire();
    ae = alu_ref(alu_src1, alu_src2, alu_op);
    if (mem_write) store_ref(ae, funct3, mem_wdata);
    if (ecall) begin
      m_mepc   = pc & ~32'd3;
      m_mcause = 32'd11;
    end else if (!mret && csr_write) begin
      csr_apply(csr_addr, csr_op, csr_wdata);
    end
    @(negedge clk);
  endtask

  task automatic csr_cycle(logic [11:0] a, logic [2:0] op, logic [31:0] wd);
    idle(); csr_addr = a; csr_op = op; csr_wdata = wd; csr_write = 1;
    begin_cycle(); end_cycle();
  endtask

  task automatic csr_check(logic [11:0] a, logic [31:0] e, string n);
    idle(); csr_addr = a;
    begin_cycle(); push(4, e, n); end_cycle();
  endtask

  task automatic mem_cycle(logic [31:0] addr, logic rd, logic wr, logic [2:0] f3, logic [31:0] wd);
    idle(); alu_op = 0; alu_src1 = addr; alu_src2 = 0;
    mem_read = rd; mem_write = wr; funct3 = f3; mem_wdata = wd;
    begin_cycle();
  endtask

  logic [11:0] csr_list [8];
  logic [11:0] reset_addrs [5];
  logic [31:0] reset_vals [5];
  logic [31:0] seg [3];

  initial begin
    csr_list = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h123,
`ifdef CSR_MCYCLE_EN
                 12'h7C0, 12'hF11};
`else
                 12'hB00, 12'hB80};
`endif
    reset_addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342};
    reset_vals  = '{32'h0000_1800, 32'd0, 32'd0, 32'd0, 32'd0};
    seg = '{BASE, BASE + DEPTH * 4, BASE - DEPTH * 4};

    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;

    // Reset values.
    for (int i = 0; i < 5; i++) csr_check(reset_addrs[i], reset_vals[i], "reset_csr");

    // ALU directed.
    idle(); alu_src1 = 32'hFFFF_FFFE; alu_src2 = 2; alu_op = 1;
    begin_cycle();
    push(0, 32'hFFFF_FFFC, "sub_result"); push(2, 1, "sub_lt"); push(1, 0, "sub_zero");
    end_cycle();
    idle(); alu_src1 = 32'hFFFF_FFFE; alu_src2 = 2; alu_op = 4;
    begin_cycle(); push(0, 0, "sltu_result"); end_cycle();
    idle(); alu_src1 = 32'hFFFF_FFFE; alu_src2 = 1; alu_op = 7;
    begin_cycle(); push(0, 32'hFFFF_FFFF, "sra_result"); end_cycle();

    // Store/load sizing.
    mem_cycle(32'h8000_0010, 0, 1, 3'b010, 32'h1234_5678); end_cycle();
    mem_cycle(32'h8000_0013, 1, 0, 3'b000, 0); push(3, 32'h12, "lb_13"); end_cycle();
    mem_cycle(32'h8000_0012, 1, 0, 3'b001, 0); push(3, 32'h1234, "lh_12"); end_cycle();
    mem_cycle(32'h8000_0011, 1, 1, 3'b000, 32'h80); push(3, 32'h56, "lb_pre_write"); end_cycle();
    mem_cycle(32'h8000_0011, 1, 0, 3'b000, 0); push(3, 32'hFFFF_FF80, "lb_11"); end_cycle();
    mem_cycle(32'h8000_0011, 1, 0, 3'b100, 0); push(3, 32'h80, "lbu_11"); end_cycle();
    mem_cycle(32'h8000_0010, 0, 0, 3'b010, 0); push(3, 0, "read_gated"); end_cycle();

    // CSR ops.
    csr_cycle(12'h305, 3'b001, 32'h8000_0103);
    csr_check(12'h305, 32'h8000_0100, "mtvec_rw");
    csr_cycle(12'h300, 3'b010, 32'd0);
    csr_check(12'h300, 32'h0000_1800, "mstatus_rs0");
    csr_cycle(12'h300, 3'b011, 32'h800);
    csr_check(12'h300, 32'h0000_1000, "mstatus_rc");
`ifndef CSR_MCYCLE_EN
    csr_cycle(12'hB00, 3'b001, 32'h55);
    csr_check(12'hB00, 32'd0, "mcycle_absent");
`endif

    // Trap sequence.
    idle(); ecall = 1; pc = 32'h8000_0040;
    begin_cycle(); push(5, 1, "ecall_flag"); push(6, 32'h8000_0100, "ecall_pc"); end_cycle();
    csr_check(12'h341, 32'h8000_0040, "mepc");
    csr_check(12'h342, 32'd11, "mcause");
    idle(); mret = 1;
    begin_cycle(); push(5, 1, "mret_flag"); push(6, 32'h8000_0040, "mret_pc"); end_cycle();

    // ecall outranks a simultaneous CSR write.
    csr_cycle(12'h340, 3'b001, 32'h1111_2222);
    idle(); ecall = 1; pc = 32'h8000_0080; csr_addr = 12'h340; csr_op = 3'b001;
    csr_wdata = 32'h0000_FFFF; csr_write = 1;
    begin_cycle(); push(5, 1, "ecall_csr_flag"); end_cycle();
    csr_check(12'h340, 32'h1111_2222, "mscratch_kept");

    // Asynchronous reset mid-cycle: CSRs reset before the next edge, RAM kept.
    csr_cycle(12'h340, 3'b001, 32'hDEAD_BEEF);
    idle();
    #2;
    rst = 0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      csr_addr = reset_addrs[i];
      #1;
      push(4, reset_vals[i], "async_reset");
      fire();
    end
    rst = 1;
    @(negedge clk);
    mem_cycle(32'h8000_0010, 1, 0, 3'b010, 0); push(3, 32'h1234_8078, "ram_retained"); end_cycle();

    // Randomized phase: initialise a 16-word pool, then mixed traffic.
    for (int k = 0; k < 16; k++) begin
      mem_cycle(BASE + 32'(4 * k), 0, 1, 3'b010, $urandom); end_cycle();
    end
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(0, 1) == 1) begin
        alu_op    = 0;
        alu_src1  = seg[$urandom_range(0, 2)];
        alu_src2  = $urandom_range(0, 63);
        mem_read  = 1'($urandom_range(0, 1));
        mem_write = 1'($urandom_range(0, 1));
        funct3    = 3'($urandom_range(0, 7));
        mem_wdata = $urandom;
      end else begin
        alu_op   = 4'($urandom_range(0, 15));
        alu_src1 = $urandom;
        case ($urandom_range(0, 3))
          0:       alu_src2 = alu_src1;
          1:       alu_src2 = $urandom_range(0, 40);
          default: alu_src2 = $urandom;
        endcase
      end
      csr_write = 1'($urandom_range(0, 1));
      csr_addr  = csr_list[$urandom_range(0, 7)];
      csr_op    = 3'($urandom_range(0, 7));
      csr_wdata = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      ecall     = ($urandom_range(0, 9) == 0);
      mret      = !ecall && ($urandom_range(0, 9) == 0);
      pc        = $urandom;
      begin_cycle();
      end_cycle();
    end

    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
